rabbit_counter_system: RTL and testbench

- Counter system and iteration sequencer for the Rabbit stream-cipher core.
- Sits directly upstream of the state-update stage: owns counters C0..C7 and carry phi, and drives C0..C7 into that stage.
- Pulses x_en to that stage once the counters have advanced.
- Sequences key setup (load, 4 iterations, counter re-initialisation) and then single keystream iterations on request.

---
 rtl/rabbit_counter_system.sv | 208 ++++++++++++++++++++
 tb/tb_rabbit_counter_system.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rabbit_counter_system.sv
// rtl/rabbit_counter_system.sv - Rabbit counter system and key-setup/keystream iteration sequencer
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   key_start           load C_init0..7 and start key setup (IDLE/RUN only)
//   C_init0..C_init7    key-derived initial counter values
//   X0..X7              state registers from the state-update stage (used in REINIT)
//   next_req            request one keystream iteration (RUN only)
//   C0..C7, phi         registered counters and counter carry
//   x_en                one-cycle enable to the state-update stage
//   busy, ready         sequencing status
//   ks_valid            new X valid for extraction
module rabbit_counter_system #(
    parameter int NITER = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start,
    input  logic [31:0] C_init0,
    input  logic [31:0] C_init1,
    input  logic [31:0] C_init2,
    input  logic [31:0] C_init3,
    input  logic [31:0] C_init4,
    input  logic [31:0] C_init5,
    input  logic [31:0] C_init6,
    input  logic [31:0] C_init7,
    input  logic [31:0] X0,
    input  logic [31:0] X1,
    input  logic [31:0] X2,
    input  logic [31:0] X3,
    input  logic [31:0] X4,
    input  logic [31:0] X5,
    input  logic [31:0] X6,
    input  logic [31:0] X7,
    input  logic        next_req,
    output logic [31:0] C0,
    output logic [31:0] C1,
    output logic [31:0] C2,
    output logic [31:0] C3,
    output logic [31:0] C4,
    output logic [31:0] C5,
    output logic [31:0] C6,
    output logic [31:0] C7,
    output logic        phi,
    output logic        x_en,
    output logic        busy,
    output logic        ready,
    output logic        ks_valid
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCTR   = 3'd1;
    localparam logic [2:0] SXUP   = 3'd2;
    localparam logic [2:0] REINIT = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] RCTR   = 3'd5;
    localparam logic [2:0] RXUP   = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    localparam int CNT_W = (NITER > 1) ? $clog2(NITER) : 1;

    localparam logic [31:0] A [8] = '{
        32'h4D34D34D, 32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D,
        32'hD34D34D3, 32'h34D34D34, 32'h4D34D34D, 32'hD34D34D3
    };

    logic [2:0]       state_q, state_d;
    logic [31:0]      c_q [8];
    logic [31:0]      c_d [8];
    logic             phi_q, phi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] x_in    [8];
    logic [31:0] c_init  [8];
    logic [31:0] step_c  [8];
    logic        step_phi;
    logic        load;

    assign x_in[0] = X0;
    assign x_in[1] = X1;
    assign x_in[2] = X2;
    assign x_in[3] = X3;
    assign x_in[4] = X4;
    assign x_in[5] = X5;
    assign x_in[6] = X6;
    assign x_in[7] = X7;

    assign c_init[0] = C_init0;
    assign c_init[1] = C_init1;
    assign c_init[2] = C_init2;
    assign c_init[3] = C_init3;
    assign c_init[4] = C_init4;
    assign c_init[5] = C_init5;
    assign c_init[6] = C_init6;
    assign c_init[7] = C_init7;

    // Full ripple carry chain across all eight counters in a single cycle;
    // phi feeds C0 and the carry out of C7 becomes the new phi.
    always_comb begin
        logic [32:0] s;
        logic        carry;
        carry = phi_q;
        s     = '0;
        for (int j = 0; j < 8; j++) begin
            s         = {1'b0, c_q[j]} + {1'b0, A[j]} + {32'd0, carry};
            step_c[j] = s[31:0];
            carry     = s[32];
        end
        step_phi = carry;
    end

    // key_start has priority over next_req in RUN and is dropped elsewhere.
    assign load = key_start && ((state_q == IDLE) || (state_q == RUN));

    always_comb begin
        state_d = state_q;
        phi_d   = phi_q;
        cnt_d   = cnt_q;
        for (int j = 0; j < 8; j++) begin
            c_d[j] = c_q[j];
        end

        case (state_q)
            IDLE: ;
            SCTR: begin
                for (int j = 0; j < 8; j++) begin
                    c_d[j] = step_c[j];
                end
                phi_d   = step_phi;
                state_d = SXUP;
            end
            SXUP: begin
                if (cnt_q < CNT_W'(NITER - 1)) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SCTR;
                end else begin
                    state_d = REINIT;
                end
            end
            REINIT: begin
                // Final key-setup mixing; phi deliberately carried through.
                for (int j = 0; j < 8; j++) begin
                    c_d[j] = c_q[j] ^ x_in[(j + 4) % 8];
                end
                state_d = RUN;
            end
            RUN: begin
                if (next_req) begin
                    state_d = RCTR;
                end
            end
            RCTR: begin
                for (int j = 0; j < 8; j++) begin
                    c_d[j] = step_c[j];
                end
                phi_d   = step_phi;
                state_d = RXUP;
            end
            RXUP:    state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (load) begin
            for (int j = 0; j < 8; j++) begin
                c_d[j] = c_init[j];
            end
            phi_d   = 1'b0;
            cnt_d   = '0;
            state_d = SCTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phi_q   <= 1'b0;
            cnt_q   <= '0;
            for (int j = 0; j < 8; j++) begin
                c_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            cnt_q   <= cnt_d;
            for (int j = 0; j < 8; j++) begin
                c_q[j] <= c_d[j];
            end
        end
    end

    assign C0  = c_q[0];
    assign C1  = c_q[1];
    assign C2  = c_q[2];
    assign C3  = c_q[3];
    assign C4  = c_q[4];
    assign C5  = c_q[5];
    assign C6  = c_q[6];
    assign C7  = c_q[7];
    assign phi = phi_q;

    // Status decodes from the state register only.
    assign x_en     = (state_q == SXUP) || (state_q == RXUP);
    assign busy     = (state_q != IDLE) && (state_q != RUN);
    assign ready    = (state_q == RUN);
    assign ks_valid = (state_q == DONE);

endmodule

// File: tb/tb_rabbit_counter_system.sv
// tb/tb_rabbit_counter_system.sv - directed self-checking bench for rabbit_counter_system
module tb_rabbit_counter_system;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_start;
    logic        next_req;
    logic [31:0] ci0, ci1, ci2, ci3, ci4, ci5, ci6, ci7;
    logic [31:0] x0, x1, x2, x3, x4, x5, x6, x7;

    logic [31:0] c0, c1, c2, c3, c4, c5, c6, c7;
    logic        phi, x_en, busy, ready, ks_valid;

    logic [31:0] u1_c0, u1_c1, u1_c2, u1_c3, u1_c4, u1_c5, u1_c6, u1_c7;
    logic        u1_phi, u1_x_en, u1_busy, u1_ready, u1_ks_valid;

    int checks = 0;
    int errors = 0;
    int xcount;
    int rdy_edge;

    always #5 clk = ~clk;

    rabbit_counter_system #(.NITER(4)) u0 (
        .clk(clk), .rst(rst), .key_start(key_start),
        .C_init0(ci0), .C_init1(ci1), .C_init2(ci2), .C_init3(ci3),
        .C_init4(ci4), .C_init5(ci5), .C_init6(ci6), .C_init7(ci7),
        .X0(x0), .X1(x1), .X2(x2), .X3(x3), .X4(x4), .X5(x5), .X6(x6), .X7(x7),
        .next_req(next_req),
        .C0(c0), .C1(c1), .C2(c2), .C3(c3), .C4(c4), .C5(c5), .C6(c6), .C7(c7),
        .phi(phi), .x_en(x_en), .busy(busy), .ready(ready), .ks_valid(ks_valid)
    );

    rabbit_counter_system #(.NITER(1)) u1 (
        .clk(clk), .rst(rst), .key_start(key_start),
        .C_init0(ci0), .C_init1(ci1), .C_init2(ci2), .C_init3(ci3),
        .C_init4(ci4), .C_init5(ci5), .C_init6(ci6), .C_init7(ci7),
        .X0(x0), .X1(x1), .X2(x2), .X3(x3), .X4(x4), .X5(x5), .X6(x6), .X7(x7),
        .next_req(next_req),
        .C0(u1_c0), .C1(u1_c1), .C2(u1_c2), .C3(u1_c3),
        .C4(u1_c4), .C5(u1_c5), .C6(u1_c6), .C7(u1_c7),
        .phi(u1_phi), .x_en(u1_x_en), .busy(u1_busy), .ready(u1_ready),
        .ks_valid(u1_ks_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        key_start = 1'b0;
        next_req = 1'b0;
        {ci0, ci1, ci2, ci3, ci4, ci5, ci6, ci7} = '0;
        {x0, x1, x2, x3, x4, x5, x6, x7} = '0;
        #12;
        chk("rst_c0", c0, 32'h0);
        chk("rst_c7", c7, 32'h0);
        chk("rst_phi", phi, 1'b0);
        chk("rst_x_en", x_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_ks_valid", ks_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // All-zero key: first step yields the A constants, 4 x_en, ready at edge 10.
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        chk("t1_busy_sctr", busy, 1'b1);
        xcount = 0;
        rdy_edge = 0;
        for (int n = 2; n <= 12; n++) begin
            tick();
            if (x_en) xcount++;
            if (ready && rdy_edge == 0) rdy_edge = n;
            if (n == 2) begin
                chk("t1_c0", c0, 32'h4D34D34D);
                chk("t1_c1", c1, 32'hD34D34D3);
                chk("t1_c2", c2, 32'h34D34D34);
                chk("t1_phi", phi, 1'b0);
            end
        end
        chk("t1_x_en_count", xcount, 4);
        chk("t1_ready_edge", rdy_edge, 10);

        // Carry from C0 into C1; key_start beats next_req in RUN.
        ci0 = 32'hFFFFFFFF;
        key_start = 1'b1;
        next_req = 1'b1;
        tick();
        key_start = 1'b0;
        next_req = 1'b0;
        ci0 = 32'h0;
        chk("t2_busy", busy, 1'b1);
        tick();
        chk("t2_c0", c0, 32'h4D34D34C);
        chk("t2_c1", c1, 32'hD34D34D4);
        chk("t2_phi", phi, 1'b0);
        for (int n = 3; n <= 10; n++) tick();
        chk("t2_ready", ready, 1'b1);

        // C7 overflow sets phi, which feeds C0 on the next step.
        ci7 = 32'h2CB2CB2D;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        ci7 = 32'h0;
        tick();
        chk("t3_c7_s1", c7, 32'h00000000);
        chk("t3_phi_s1", phi, 1'b1);
        chk("t3_c0_s1", c0, 32'h4D34D34D);
        // key_start during setup must be ignored.
        ci0 = 32'hFFFFFFFF;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        ci0 = 32'h0;
        tick();
        chk("t3_c0_s2", c0, 32'h9A69A69B);
        chk("t3_c7_s2", c7, 32'hD34D34D3);
        chk("t3_phi_s2", phi, 1'b0);
        chk("t3_ks_valid", ks_valid, 1'b0);
        for (int n = 5; n <= 10; n++) tick();
        chk("t3_ready", ready, 1'b1);

        // NITER=1 instance: REINIT mixes X4 into C0.
        x4 = 32'h12345678;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        tick();
        chk("t4_u1_x_en", u1_x_en, 1'b1);
        tick();
        chk("t4_u1_busy_reinit", u1_busy, 1'b1);
        tick();
        chk("t4_u1_c0", u1_c0, 32'h5F008535);
        chk("t4_u1_c4", u1_c4, 32'hD34D34D3);
        chk("t4_u1_phi", u1_phi, 1'b0);
        chk("t4_u1_ready", u1_ready, 1'b1);
        x4 = 32'h0;
        for (int n = 5; n <= 10; n++) tick();
        chk("t4_u0_ready", ready, 1'b1);

        // next_req held: one iteration per 4 cycles.
        next_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t5_x_en_%0d", i), x_en, (i % 4) == 2);
            chk($sformatf("t5_ks_valid_%0d", i), ks_valid, (i % 4) == 3);
            chk($sformatf("t5_ready_%0d", i), ready, (i % 4) == 0);
        end
        next_req = 1'b0;
        tick();
        chk("t5_done_tail", ks_valid, 1'b1);
        tick();
        chk("t5_ready_back", ready, 1'b1);
        tick();
        chk("t5_no_queue", ready, 1'b1);

        // Reset during SXUP of iteration 2.
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_sxup2_x_en", x_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_c0", c0, 32'h0);
        chk("t6_rst_c1", c1, 32'h0);
        chk("t6_rst_phi", phi, 1'b0);
        chk("t6_rst_x_en", x_en, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_ready", ready, 1'b0);
            chk("t6_idle_busy", busy, 1'b0);
        end
        next_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
